// File: rtl/disp_median3x3.sv
// disp_median3x3: streaming 3x3 median filter for 6-bit disparity, two line buffers, 4-stage pipeline.
// Optional macro DISP_MEDIAN_BYPASS_EN adds a bypass port that passes the window centre instead.
module disp_median3x3 #(
    parameter int DW     = 6,
    parameter int LINE_W = 320,
    parameter int ROW_W  = 10
) (
    input  logic          clk,
    input  logic          reset,
`ifdef DISP_MEDIAN_BYPASS_EN
    input  logic          bypass,
`endif
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_eol,
    input  logic [DW-1:0] in_disp,
    output logic          out_valid,
    output logic          out_sof,
    output logic          out_eol,
    output logic [DW-1:0] out_disp
);
    localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    function automatic logic [DW-1:0] mn(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DW-1:0] md3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    state_t state, state_nxt;
    logic accept;

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_SOF;
        else state <= state_nxt;
    end

    always_comb state_nxt = (in_valid && in_sof) ? ACTIVE : state;

    always_comb accept = in_valid && (state == ACTIVE || in_sof);

    // ovf marks beats past the end of the line buffers (raw column >= LINE_W)
    logic [CW-1:0]    col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    logic             ovf, cur_ovf, col_last;

    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        cur_ovf  = in_sof ? 1'b0 : ovf;
        col_last = cur_col == CW'(LINE_W - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            col <= in_eol ? '0 : (col_last ? cur_col : cur_col + 1'b1);
            row <= in_eol ? ((&cur_row) ? cur_row : cur_row + 1'b1) : cur_row;
            ovf <= in_eol ? 1'b0 : (cur_ovf | col_last);
        end
    end

    logic [DW-1:0] lb0 [LINE_W];
    logic [DW-1:0] lb1 [LINE_W];
    logic [DW-1:0] lb0_rd, lb1_rd;

    always_comb begin
        lb0_rd = lb0[cur_col];
        lb1_rd = lb1[cur_col];
    end

    always_ff @(posedge clk) begin
        if (accept && !cur_ovf) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= in_disp;
        end
    end

    // Window row 0 is r-2, row 2 is the live row; column 2 is the newest
    logic [DW-1:0] w [3][3];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                w[i][0] <= w[i][1];
                w[i][1] <= w[i][2];
            end
            w[0][2] <= lb1_rd;
            w[1][2] <= lb0_rd;
            w[2][2] <= in_disp;
        end
    end

    logic v1, v2, v3;
    logic sof1, eol1, bdr1, byp1;
    logic sof2, eol2, bdr2, byp2;
    logic sof3, eol3, bdr3, byp3;
    logic [DW-1:0] lo2 [3];
    logic [DW-1:0] md2 [3];
    logic [DW-1:0] hi2 [3];
    logic [DW-1:0] ctr2, ctr3, a3, b3, c3;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sof1 <= in_sof;
            eol1 <= in_eol;
            bdr1 <= cur_ovf || (cur_row[ROW_W-1:1] == '0) || (cur_col[CW-1:1] == '0);
`ifdef DISP_MEDIAN_BYPASS_EN
            byp1 <= bypass;
`else
            byp1 <= 1'b0;
`endif
        end
        for (int j = 0; j < 3; j++) begin
            lo2[j] <= mn(mn(w[0][j], w[1][j]), w[2][j]);
            md2[j] <= md3(w[0][j], w[1][j], w[2][j]);
            hi2[j] <= mx(mx(w[0][j], w[1][j]), w[2][j]);
        end
        ctr2 <= w[1][1];
        {sof2, eol2, bdr2, byp2} <= {sof1, eol1, bdr1, byp1};
        a3   <= mx(mx(lo2[0], lo2[1]), lo2[2]);
        b3   <= md3(md2[0], md2[1], md2[2]);
        c3   <= mn(mn(hi2[0], hi2[1]), hi2[2]);
        ctr3 <= ctr2;
        {sof3, eol3, bdr3, byp3} <= {sof2, eol2, bdr2, byp2};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_disp  <= '0;
        end else begin
            out_valid <= v3;
            out_sof   <= v3 && sof3;
            out_eol   <= v3 && eol3;
            out_disp  <= (v3 && !bdr3) ? (byp3 ? ctr3 : md3(a3, b3, c3)) : '0;
        end
    end
endmodule

// File: tb/tb_disp_median3x3.sv
// tb_disp_median3x3: directed checks of the 3x3 disparity median filter on an 8x4 frame.
module tb_disp_median3x3;
    localparam int DW = 6;
    localparam int LW = 8;
    localparam int NR = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
    logic [DW-1:0] in_disp = '0;
`ifdef DISP_MEDIAN_BYPASS_EN
    logic bypass = 1'b0;
`endif
    logic out_valid, out_sof, out_eol;
    logic [DW-1:0] out_disp;

    int checks = 0, failures = 0, cyc = 0;
    logic [DW-1:0] img [NR][LW];
    int in_t[$];
    int cap_t[$];
    logic [DW-1:0] cap_d[$];
    logic cap_s[$], cap_e[$];

    disp_median3x3 #(.DW(DW), .LINE_W(LW), .ROW_W(10)) dut (
        .clk(clk), .reset(reset),
`ifdef DISP_MEDIAN_BYPASS_EN
        .bypass(bypass),
`endif
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol), .in_disp(in_disp),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol), .out_disp(out_disp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            cap_t.push_back(cyc);
            cap_d.push_back(out_disp);
            cap_s.push_back(out_sof);
            cap_e.push_back(out_eol);
        end
    end

    // Reference: true median of the 9 neighbours by full sort, zero on the border
    function automatic logic [DW-1:0] med_exp(input int r, input int c);
        logic [DW-1:0] v [9];
        logic [DW-1:0] t;
        if (r < 2 || c < 2) return '0;
        for (int i = 0; i < 9; i++) v[i] = img[r - 2 + i / 3][c - 2 + i % 3];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j + 1]) begin
                    t = v[j]; v[j] = v[j + 1]; v[j + 1] = t;
                end
        return v[4];
    endfunction

    task automatic clear_q();
        in_t.delete(); cap_t.delete(); cap_d.delete(); cap_s.delete(); cap_e.delete();
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
        @(negedge clk);
        in_valid = v; in_sof = s; in_eol = e; in_disp = d;
        if (v) in_t.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < LW; c++) begin
                beat(1'b1, r == 0 && c == 0, c == LW - 1, img[r][c]);
                if (gaps) beat(1'b0, 1'b0, 1'b0, '0);
            end
        idle(8);
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int r = 0; r < NR; r++) for (int c = 0; c < LW; c++) img[r][c] = v;
    endtask

    task automatic set_window(input logic [DW-1:0] centre);
        fill('0);
        img[1][2] = 1; img[1][3] = 9;      img[1][4] = 2;
        img[2][2] = 8; img[2][3] = centre; img[2][4] = 7;
        img[3][2] = 3; img[3][3] = 6;      img[3][4] = 4;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        if (out_sof !== 1'b0) begin failures++; $display("FAIL reset_sof got=%b exp=0", out_sof); end
        if (out_eol !== 1'b0) begin failures++; $display("FAIL reset_eol got=%b exp=0", out_eol); end
        if (out_disp !== '0) begin failures++; $display("FAIL reset_disp got=%0d exp=0", out_disp); end
        reset = 1'b0;
    endtask

    task automatic test_no_sof();
        clear_q();
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b0, DW'(10 + i));
        idle(8);
        checks++;
        if (cap_d.size() != 0) begin failures++; $display("FAIL no_sof_count got=%0d exp=0", cap_d.size()); end
        clear_q();
        beat(1'b1, 1'b1, 1'b0, 6'd33);
        idle(8);
        checks++;
        if (cap_d.size() != 1) begin
            failures++; $display("FAIL sof_count got=%0d exp=1", cap_d.size());
        end else begin
            checks += 3;
            if (cap_t[0] - in_t[0] != 4) begin failures++; $display("FAIL sof_latency got=%0d exp=4", cap_t[0] - in_t[0]); end
            if (cap_s[0] !== 1'b1) begin failures++; $display("FAIL sof_flag got=%b exp=1", cap_s[0]); end
            if (cap_d[0] !== '0) begin failures++; $display("FAIL sof_disp got=%0d exp=0", cap_d[0]); end
        end
    endtask

    task automatic test_const();
        int n21;
        clear_q();
        fill(6'd21);
        send_frame(1'b0);
        n21 = 0;
        checks++;
        if (cap_d.size() != NR * LW) begin failures++; $display("FAIL const_count got=%0d exp=%0d", cap_d.size(), NR * LW); end
        for (int i = 0; i < cap_d.size() && i < NR * LW; i++) begin
            checks += 4;
            if (cap_t[i] - in_t[i] != 4) begin failures++; $display("FAIL const_latency i=%0d got=%0d exp=4", i, cap_t[i] - in_t[i]); end
            if (cap_d[i] !== ((i / LW < 2 || i % LW < 2) ? 6'd0 : 6'd21)) begin
                failures++; $display("FAIL const_disp i=%0d got=%0d", i, cap_d[i]);
            end
            if (cap_s[i] !== (i == 0)) begin failures++; $display("FAIL const_sof i=%0d got=%b", i, cap_s[i]); end
            if (cap_e[i] !== (i % LW == LW - 1)) begin failures++; $display("FAIL const_eol i=%0d got=%b", i, cap_e[i]); end
            if (cap_d[i] == 6'd21) n21++;
        end
        checks++;
        if (n21 != 12) begin failures++; $display("FAIL const_n21 got=%0d exp=12", n21); end
    endtask

    task automatic test_impulse();
        clear_q();
        fill('0);
        img[1][3] = 6'd63;
        send_frame(1'b0);
        checks++;
        if (cap_d.size() != NR * LW) begin failures++; $display("FAIL imp_count got=%0d exp=%0d", cap_d.size(), NR * LW); end
        for (int i = 0; i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== '0) begin failures++; $display("FAIL imp_disp i=%0d got=%0d exp=0", i, cap_d[i]); end
        end
    endtask

    task automatic test_bubble();
        logic [DW-1:0] ref_d [$];
        for (int r = 0; r < NR; r++) for (int c = 0; c < LW; c++) img[r][c] = DW'((r * 13 + c * 7 + (r ^ c) * 5) % 64);
        clear_q();
        send_frame(1'b0);
        ref_d = cap_d;
        clear_q();
        send_frame(1'b1);
        checks++;
        if (cap_d.size() != NR * LW || ref_d.size() != NR * LW) begin
            failures++; $display("FAIL bub_count got=%0d/%0d exp=%0d", ref_d.size(), cap_d.size(), NR * LW);
        end
        for (int i = 0; i < cap_d.size() && i < ref_d.size(); i++) begin
            checks += 3;
            if (cap_t[i] - in_t[i] != 4) begin failures++; $display("FAIL bub_latency i=%0d got=%0d exp=4", i, cap_t[i] - in_t[i]); end
            if (cap_d[i] !== ref_d[i]) begin failures++; $display("FAIL bub_vs_gapfree i=%0d got=%0d exp=%0d", i, cap_d[i], ref_d[i]); end
            if (cap_d[i] !== med_exp(i / LW, i % LW)) begin
                failures++; $display("FAIL bub_model i=%0d got=%0d exp=%0d", i, cap_d[i], med_exp(i / LW, i % LW));
            end
        end
    endtask

    task automatic test_window();
        clear_q();
        set_window(6'd5);
        send_frame(1'b0);
        checks++;
        if (cap_d.size() != NR * LW) begin
            failures++; $display("FAIL win_count got=%0d exp=%0d", cap_d.size(), NR * LW);
        end else begin
            checks++;
            if (cap_d[3 * LW + 4] !== 6'd5) begin failures++; $display("FAIL win_median got=%0d exp=5", cap_d[3 * LW + 4]); end
            for (int i = 0; i < NR * LW; i++) begin
                checks++;
                if (cap_d[i] !== med_exp(i / LW, i % LW)) begin
                    failures++; $display("FAIL win_model i=%0d got=%0d exp=%0d", i, cap_d[i], med_exp(i / LW, i % LW));
                end
            end
        end
        clear_q();
        set_window(6'd9);
        send_frame(1'b0);
        checks++;
        if (cap_d.size() != NR * LW) begin
            failures++; $display("FAIL win9_count got=%0d exp=%0d", cap_d.size(), NR * LW);
        end else if (cap_d[3 * LW + 4] !== 6'd6) begin
            failures++; $display("FAIL win9_median got=%0d exp=6", cap_d[3 * LW + 4]);
        end
    endtask

    task automatic test_reset_mid();
        int rc, bad, n_after, first;
        for (int r = 0; r < NR; r++) for (int c = 0; c < LW; c++) img[r][c] = DW'(r * 8 + c + 3);
        clear_q();
        for (int r = 0; r < 2; r++) for (int c = 0; c < LW; c++) beat(1'b1, r == 0 && c == 0, c == LW - 1, img[r][c]);
        for (int c = 0; c < 3; c++) beat(1'b1, 1'b0, 1'b0, img[2][c]);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_eol = 1'b0; in_disp = img[2][3];
        rc = cyc;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 4; c < LW; c++) beat(1'b1, 1'b0, c == LW - 1, img[2][c]);
        idle(3);
        in_t.delete();
        send_frame(1'b0);
        bad = 0; n_after = 0; first = -1;
        for (int i = 0; i < cap_t.size(); i++)
            if (cap_t[i] > rc) begin
                if (cap_t[i] < in_t[0] + 4) bad++;
                if (first < 0) first = i;
                n_after++;
            end
        checks += 2;
        if (bad != 0) begin failures++; $display("FAIL rst_quiet got=%0d early beats exp=0", bad); end
        if (n_after != NR * LW) begin failures++; $display("FAIL rst_count got=%0d exp=%0d", n_after, NR * LW); end
        if (first >= 0) begin
            checks += 2;
            if (cap_t[first] - in_t[0] != 4) begin failures++; $display("FAIL rst_first_latency got=%0d exp=4", cap_t[first] - in_t[0]); end
            if (cap_s[first] !== 1'b1) begin failures++; $display("FAIL rst_first_sof got=%b exp=1", cap_s[first]); end
        end
    endtask

`ifdef DISP_MEDIAN_BYPASS_EN
    task automatic test_bypass();
        bypass = 1'b1;
        clear_q();
        set_window(6'd5);
        img[1][0] = 6'd40;
        send_frame(1'b0);
        checks++;
        if (cap_d.size() != NR * LW) begin
            failures++; $display("FAIL byp_count got=%0d exp=%0d", cap_d.size(), NR * LW);
        end else begin
            checks += 2;
            if (cap_d[3 * LW + 4] !== 6'd5) begin failures++; $display("FAIL byp_centre5 got=%0d exp=5", cap_d[3 * LW + 4]); end
            if (cap_d[2 * LW + 1] !== 6'd0) begin failures++; $display("FAIL byp_border got=%0d exp=0", cap_d[2 * LW + 1]); end
        end
        clear_q();
        set_window(6'd9);
        send_frame(1'b0);
        checks++;
        if (cap_d.size() != NR * LW) begin
            failures++; $display("FAIL byp9_count got=%0d exp=%0d", cap_d.size(), NR * LW);
        end else if (cap_d[3 * LW + 4] !== 6'd9) begin
            failures++; $display("FAIL byp_centre9 got=%0d exp=9", cap_d[3 * LW + 4]);
        end
        bypass = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_no_sof();
        test_const();
        test_impulse();
        test_bubble();
        test_window();
        test_reset_mid();
`ifdef DISP_MEDIAN_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
